cpu_bus_decoder: RTL and testbench

Address decoder and transaction sequencer between the PicoRV32 native memory port and its slaves: the on-chip `cpu_memory` RAM and a single MMIO window for peripherals. It accepts one CPU transaction at a time and forwards it to exactly one slave with a registered valid. It returns that slave's ready and read data to the CPU, registered. Unmapped accesses and slaves that never respond are terminated with an error response, so the CPU never hangs.

---
 rtl/cpu_bus_decoder_pkg.sv | 30 +++
 rtl/cpu_bus_decoder_bus_watchdog.sv | 40 ++++
 rtl/cpu_bus_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_cpu_bus_decoder.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_decoder_pkg.sv
// rtl/cpu_bus_decoder_pkg.sv - shared states, error data words and default address map
package cpu_bus_decoder_pkg;

   // Decoder sequencer states
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RAM_WAIT  = 3'd1,
      ST_MMIO_WAIT = 3'd2,
      ST_ERR       = 3'd3,
      ST_DONE      = 3'd4
   } bus_state_e;

   // Read data returned on unmapped accesses and on slave timeouts
   localparam logic [31:0] BUS_ERR_RDATA     = 32'hFFFF_FFFF;
   localparam logic [31:0] BUS_TIMEOUT_RDATA = 32'hDEAD_BEEF;

   // Default address map
   localparam int unsigned DEF_MEM_DEPTH = 65536;
   localparam logic [31:0] DEF_MMIO_BASE = 32'h1000_0000;
   localparam logic [31:0] DEF_MMIO_SIZE = 32'h0000_1000;
   localparam int unsigned DEF_TIMEOUT   = 255;

   // Half-open window test done in 33 bits so base+size never wraps
   function automatic logic addr_in_window(input logic [31:0] addr,
                                           input logic [32:0] lo,
                                           input logic [32:0] hi);
      return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
   endfunction

endpackage

// File: rtl/cpu_bus_decoder_bus_watchdog.sv
// rtl/cpu_bus_decoder_bus_watchdog.sv - 16-bit wait counter flagging a slave that never answers
module bus_watchdog
   import cpu_bus_decoder_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

   logic [15:0] count_q;
   logic [15:0] count_d;

   // Clear wins over count; the sequencer leaves the wait state before any wrap
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + 16'd1;
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == TIMEOUT_CNT);

endmodule

// File: rtl/cpu_bus_decoder.sv
// rtl/cpu_bus_decoder.sv - PicoRV32 memory port decoder and sequencer for RAM and one MMIO window
module cpu_bus_decoder
   import cpu_bus_decoder_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
   parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
   parameter logic [31:0] MMIO_SIZE = DEF_MMIO_SIZE,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        ram_valid,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   output logic [3:0]  ram_wstrb,
   input  logic        ram_ready,
   input  logic [31:0] ram_rdata,
   output logic        mmio_valid,
   output logic [31:0] mmio_addr,
   output logic [31:0] mmio_wdata,
   output logic [3:0]  mmio_wstrb,
   input  logic        mmio_ready,
   input  logic [31:0] mmio_rdata,
   output logic        bus_error,
   output logic [31:0] err_addr,
   output logic [7:0]  err_count
);

   localparam logic [32:0] RAM_LO  = 33'd0;
   localparam logic [32:0] RAM_HI  = 33'(MEM_DEPTH);
   localparam logic [32:0] MMIO_LO = {1'b0, MMIO_BASE};
   localparam logic [32:0] MMIO_HI = {1'b0, MMIO_BASE} + {1'b0, MMIO_SIZE};

   // A map where the MMIO window overlaps RAM, or a zero/oversized timeout, must not build
   generate
      if ((MMIO_SIZE != 32'd0 && MMIO_LO < RAM_HI) || TIMEOUT == 0 || TIMEOUT > 65535) begin : g_bad_params
         $error("cpu_bus_decoder: overlapping address map or TIMEOUT outside 1..65535");
      end
   endgenerate

   bus_state_e  state_q, state_d;
   logic        mem_ready_q, mem_ready_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;
   logic        ram_valid_q, ram_valid_d;
   logic        mmio_valid_q, mmio_valid_d;
   logic [31:0] ram_addr_q, ram_addr_d;
   logic [31:0] mmio_addr_q, mmio_addr_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] req_wdata_q, req_wdata_d;
   logic [3:0]  req_wstrb_q, req_wstrb_d;
   logic        bus_error_q, bus_error_d;
   logic [31:0] err_addr_q, err_addr_d;
   logic [7:0]  err_count_q, err_count_d;

   logic ram_hit;
   logic mmio_hit;
   logic wd_clear;
   logic wd_enable;
   logic wd_expired;

   assign ram_hit   = addr_in_window(mem_addr, RAM_LO, RAM_HI);
   assign mmio_hit  = addr_in_window(mem_addr, MMIO_LO, MMIO_HI);
   assign wd_clear  = (state_q == ST_DONE);
   assign wd_enable = (state_q == ST_RAM_WAIT) || (state_q == ST_MMIO_WAIT);

   bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   // Next-state and output logic; slave ready is only honoured in its own wait state
   always_comb begin
      state_d      = state_q;
      mem_ready_d  = mem_ready_q;
      mem_rdata_d  = mem_rdata_q;
      ram_valid_d  = ram_valid_q;
      mmio_valid_d = mmio_valid_q;
      ram_addr_d   = ram_addr_q;
      mmio_addr_d  = mmio_addr_q;
      req_addr_d   = req_addr_q;
      req_wdata_d  = req_wdata_q;
      req_wstrb_d  = req_wstrb_q;
      bus_error_d  = 1'b0;
      err_addr_d   = err_addr_q;
      err_count_d  = err_count_q;

      case (state_q)
         ST_IDLE: begin
            if (mem_valid && !mem_ready_q) begin
               ram_addr_d  = mem_addr;
               mmio_addr_d = mem_addr - MMIO_BASE;
               req_addr_d  = mem_addr;
               req_wdata_d = mem_wdata;
               req_wstrb_d = mem_wstrb;
               if (ram_hit) begin
                  ram_valid_d = 1'b1;
                  state_d     = ST_RAM_WAIT;
               end else if (mmio_hit) begin
                  mmio_valid_d = 1'b1;
                  state_d      = ST_MMIO_WAIT;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_RAM_WAIT: begin
            if (ram_ready) begin
               mem_rdata_d = ram_rdata;
               mem_ready_d = 1'b1;
               ram_valid_d = 1'b0;
               state_d     = ST_DONE;
            end else if (wd_expired) begin
               ram_valid_d = 1'b0;
               mem_rdata_d = BUS_TIMEOUT_RDATA;
               mem_ready_d = 1'b1;
               bus_error_d = 1'b1;
               err_addr_d  = req_addr_q;
               err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
               state_d     = ST_DONE;
            end
         end
         ST_MMIO_WAIT: begin
            if (mmio_ready) begin
               mem_rdata_d  = mmio_rdata;
               mem_ready_d  = 1'b1;
               mmio_valid_d = 1'b0;
               state_d      = ST_DONE;
            end else if (wd_expired) begin
               mmio_valid_d = 1'b0;
               mem_rdata_d  = BUS_TIMEOUT_RDATA;
               mem_ready_d  = 1'b1;
               bus_error_d  = 1'b1;
               err_addr_d   = req_addr_q;
               err_count_d  = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
               state_d      = ST_DONE;
            end
         end
         ST_ERR: begin
            mem_rdata_d = BUS_ERR_RDATA;
            mem_ready_d = 1'b1;
            bus_error_d = 1'b1;
            err_addr_d  = req_addr_q;
            err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            mem_ready_d = 1'b0;
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         mem_ready_q  <= 1'b0;
         mem_rdata_q  <= '0;
         ram_valid_q  <= 1'b0;
         mmio_valid_q <= 1'b0;
         ram_addr_q   <= '0;
         mmio_addr_q  <= '0;
         req_addr_q   <= '0;
         req_wdata_q  <= '0;
         req_wstrb_q  <= '0;
         bus_error_q  <= 1'b0;
         err_addr_q   <= '0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         mem_ready_q  <= mem_ready_d;
         mem_rdata_q  <= mem_rdata_d;
         ram_valid_q  <= ram_valid_d;
         mmio_valid_q <= mmio_valid_d;
         ram_addr_q   <= ram_addr_d;
         mmio_addr_q  <= mmio_addr_d;
         req_addr_q   <= req_addr_d;
         req_wdata_q  <= req_wdata_d;
         req_wstrb_q  <= req_wstrb_d;
         bus_error_q  <= bus_error_d;
         err_addr_q   <= err_addr_d;
         err_count_q  <= err_count_d;
      end
   end

   assign mem_ready  = mem_ready_q;
   assign mem_rdata  = mem_rdata_q;
   assign ram_valid  = ram_valid_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = req_wdata_q;
   assign ram_wstrb  = req_wstrb_q;
   assign mmio_valid = mmio_valid_q;
   assign mmio_addr  = mmio_addr_q;
   assign mmio_wdata = req_wdata_q;
   assign mmio_wstrb = req_wstrb_q;
   assign bus_error  = bus_error_q;
   assign err_addr   = err_addr_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_cpu_bus_decoder.sv
// tb/tb_cpu_bus_decoder.sv - scoreboard bench for cpu_bus_decoder with RAM and MMIO slave models
module tb_cpu_bus_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        ram_valid;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_wstrb;
   logic        ram_ready;
   logic [31:0] ram_rdata;
   logic        mmio_valid;
   logic [31:0] mmio_addr;
   logic [31:0] mmio_wdata;
   logic [3:0]  mmio_wstrb;
   logic        mmio_ready;
   logic [31:0] mmio_rdata;
   logic        bus_error;
   logic [31:0] err_addr;
   logic [7:0]  err_count;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   typedef struct {
      logic [31:0] rd;
      int          lat;
      logic        berr_rdy;
      int          berr_tot;
      logic        ram_seen;
      logic        mmio_seen;
      logic [31:0] mmio_a;
      logic        slv_at_rdy;
      logic        valid_at1;
   } obs_t;

   exp_t sb[$];
   int          exp_err_cnt = 0;

   always #5 clk = ~clk;

   cpu_bus_decoder #(
      .MEM_DEPTH (65536),
      .MMIO_BASE (32'h1000_0000),
      .MMIO_SIZE (32'h0000_1000),
      .TIMEOUT   (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_valid  (mem_valid),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .ram_valid  (ram_valid),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_wstrb  (ram_wstrb),
      .ram_ready  (ram_ready),
      .ram_rdata  (ram_rdata),
      .mmio_valid (mmio_valid),
      .mmio_addr  (mmio_addr),
      .mmio_wdata (mmio_wdata),
      .mmio_wstrb (mmio_wstrb),
      .mmio_ready (mmio_ready),
      .mmio_rdata (mmio_rdata),
      .bus_error  (bus_error),
      .err_addr   (err_addr),
      .err_count  (err_count)
   );

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'h1234_5678;
      return {i[7:0], 8'hC3, i[7:0], 8'h3C};
   endfunction

   // One-cycle RAM model: answers a valid one edge later, returns old data, applies byte strobes
   logic [31:0] ram_mem [0:63];
   logic        ram_ready_r = 1'b0;
   logic [31:0] ram_rdata_r = '0;
   assign ram_ready = ram_ready_r;
   assign ram_rdata = ram_rdata_r;

   always @(posedge clk) begin
      if (rst) begin
         ram_ready_r <= 1'b0;
         for (int i = 0; i < 64; i++) ram_mem[i] <= init_word(i);
      end else if (ram_valid && !ram_ready_r) begin
         ram_ready_r <= 1'b1;
         ram_rdata_r <= ram_mem[ram_addr[7:2]];
         for (int b = 0; b < 4; b++)
            if (ram_wstrb[b]) ram_mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
         ram_ready_r <= 1'b0;
      end
   end

   // MMIO model: ready after mmio_delay valid cycles, never when mmio_delay is 0
   int          mmio_delay = 1;
   logic [31:0] mmio_resp  = '0;
   logic        mmio_force = 1'b0;
   int          mmio_cnt   = 0;
   logic        mmio_ready_r = 1'b0;
   logic [31:0] mmio_rdata_r = '0;
   assign mmio_ready = mmio_ready_r | mmio_force;
   assign mmio_rdata = mmio_rdata_r;

   always @(posedge clk) begin
      if (mmio_valid && !mmio_ready_r && mmio_delay != 0) begin
         mmio_cnt <= mmio_cnt + 1;
         if (mmio_cnt + 1 == mmio_delay) begin
            mmio_ready_r <= 1'b1;
            mmio_rdata_r <= mmio_resp;
         end
      end else begin
         mmio_ready_r <= 1'b0;
         mmio_cnt     <= 0;
      end
   end

   task automatic cpu_access(input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] ws, output obs_t o);
      o = '{rd: 32'h0, lat: 0, berr_rdy: 1'b0, berr_tot: 0, ram_seen: 1'b0,
            mmio_seen: 1'b0, mmio_a: 32'h0, slv_at_rdy: 1'b0, valid_at1: 1'b0};
      @(negedge clk);
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wdata = wd;
      mem_wstrb = ws;
      while (o.lat < 40) begin
         @(posedge clk);
         #1;
         o.lat++;
         if (bus_error) o.berr_tot++;
         if (ram_valid) o.ram_seen = 1'b1;
         if (mmio_valid) begin
            o.mmio_seen = 1'b1;
            o.mmio_a    = mmio_addr;
         end
         if (o.lat == 1) o.valid_at1 = ram_valid | mmio_valid;
         if (mem_ready) begin
            o.rd         = mem_rdata;
            o.berr_rdy   = bus_error;
            o.slv_at_rdy = ram_valid | mmio_valid;
            break;
         end
      end
      mem_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_valid = 1'b0;
      mem_addr = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      repeat (3) @(posedge clk);
      #1;
      tot_cnt++; if ({mem_ready, ram_valid, mmio_valid, bus_error} !== 4'b0)
         $display("FAIL reset_flags got %b want 0000", {mem_ready, ram_valid, mmio_valid, bus_error}); else pass_cnt++;
      tot_cnt++; if (mem_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", mem_rdata); else pass_cnt++;
      tot_cnt++; if (err_addr !== 32'h0) $display("FAIL reset_err_addr got %h want 0", err_addr); else pass_cnt++;
      tot_cnt++; if (err_count !== 8'h0) $display("FAIL reset_err_count got %0d want 0", err_count); else pass_cnt++;
      tot_cnt++; if ({ram_addr, ram_wdata, ram_wstrb} !== 68'h0)
         $display("FAIL reset_ram_port got %h %h %h want 0", ram_addr, ram_wdata, ram_wstrb); else pass_cnt++;
      tot_cnt++; if ({mmio_addr, mmio_wdata, mmio_wstrb} !== 68'h0)
         $display("FAIL reset_mmio_port got %h %h %h want 0", mmio_addr, mmio_wdata, mmio_wstrb); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_ram_read();
      obs_t o;
      exp_t e;
      sb.push_back('{rdata: 32'h1234_5678, err: 1'b0, lat: 3});
      cpu_access(32'h0000_0010, 32'h0, 4'h0, o);
      e = sb.pop_front();
      tot_cnt++; if (o.rd !== e.rdata) $display("FAIL ram_read_rdata got %h want %h", o.rd, e.rdata); else pass_cnt++;
      tot_cnt++; if (o.lat !== e.lat) $display("FAIL ram_read_latency got %0d want %0d", o.lat, e.lat); else pass_cnt++;
      tot_cnt++; if (o.berr_tot !== 0) $display("FAIL ram_read_bus_error got %0d want 0", o.berr_tot); else pass_cnt++;
      tot_cnt++; if (o.valid_at1 !== 1'b1) $display("FAIL ram_read_valid_edge0 got %b want 1", o.valid_at1); else pass_cnt++;
      tot_cnt++; if (o.slv_at_rdy !== 1'b0) $display("FAIL ram_read_valid_drop got %b want 0", o.slv_at_rdy); else pass_cnt++;
      tot_cnt++; if (o.mmio_seen !== 1'b0) $display("FAIL ram_read_mmio_idle got %b want 0", o.mmio_seen); else pass_cnt++;
      @(posedge clk);
      #1;
      tot_cnt++; if (mem_ready !== 1'b0) $display("FAIL ram_read_ready_width got %b want 0", mem_ready); else pass_cnt++;
      sb.push_back('{rdata: 32'h3FC3_3F3C, err: 1'b0, lat: 3});
      cpu_access(32'h0000_FFFC, 32'h0, 4'h0, o);
      e = sb.pop_front();
      tot_cnt++; if (o.rd !== e.rdata || o.lat !== e.lat)
         $display("FAIL ram_top_word got %h/%0d want %h/%0d", o.rd, o.lat, e.rdata, e.lat); else pass_cnt++;
      @(posedge clk);
   endtask

   task automatic test_byte_write();
      obs_t o;
      exp_t e;
      sb.push_back('{rdata: 32'h08C3_083C, err: 1'b0, lat: 3});
      cpu_access(32'h0000_0020, 32'h00AB_0000, 4'b0100, o);
      e = sb.pop_front();
      tot_cnt++; if (o.rd !== e.rdata || o.lat !== e.lat)
         $display("FAIL byte_write_resp got %h/%0d want %h/%0d", o.rd, o.lat, e.rdata, e.lat); else pass_cnt++;
      @(posedge clk);
      sb.push_back('{rdata: 32'h08AB_083C, err: 1'b0, lat: 3});
      cpu_access(32'h0000_0020, 32'h0, 4'h0, o);
      e = sb.pop_front();
      tot_cnt++; if (o.rd !== e.rdata) $display("FAIL byte_write_readback got %h want %h", o.rd, e.rdata); else pass_cnt++;
      @(posedge clk);
   endtask

   task automatic test_mmio_read();
      obs_t o;
      exp_t e;
      mmio_delay = 5;
      mmio_resp  = 32'hCAFE_0001;
      sb.push_back('{rdata: 32'hCAFE_0001, err: 1'b0, lat: 7});
      cpu_access(32'h1000_0008, 32'h0, 4'h0, o);
      e = sb.pop_front();
      tot_cnt++; if (o.rd !== e.rdata) $display("FAIL mmio_read_rdata got %h want %h", o.rd, e.rdata); else pass_cnt++;
      tot_cnt++; if (o.lat !== e.lat) $display("FAIL mmio_read_latency got %0d want %0d", o.lat, e.lat); else pass_cnt++;
      tot_cnt++; if (o.mmio_a !== 32'h8) $display("FAIL mmio_read_offset got %h want 00000008", o.mmio_a); else pass_cnt++;
      tot_cnt++; if (o.ram_seen !== 1'b0) $display("FAIL mmio_read_ram_idle got %b want 0", o.ram_seen); else pass_cnt++;
      tot_cnt++; if (o.berr_tot !== 0) $display("FAIL mmio_read_bus_error got %0d want 0", o.berr_tot); else pass_cnt++;
      @(posedge clk);
      mmio_delay = 1;
      mmio_resp  = 32'h5A5A_0FFC;
      sb.push_back('{rdata: 32'h5A5A_0FFC, err: 1'b0, lat: 3});
      cpu_access(32'h1000_0FFC, 32'h0, 4'h0, o);
      e = sb.pop_front();
      tot_cnt++; if (o.rd !== e.rdata || o.lat !== e.lat || o.mmio_a !== 32'hFFC)
         $display("FAIL mmio_top_word got %h/%0d/%h want %h/%0d/00000ffc", o.rd, o.lat, o.mmio_a, e.rdata, e.lat); else pass_cnt++;
      @(posedge clk);
   endtask

   task automatic test_unmapped();
      obs_t o;
      exp_t e;
      logic [31:0] addrs [5];
      addrs = '{32'h2000_0000, 32'h0001_0000, 32'h1000_1000, 32'h0FFF_FFFC, 32'hFFFF_FFFC};
      for (int k = 0; k < 5; k++) begin
         sb.push_back('{rdata: 32'hFFFF_FFFF, err: 1'b1, lat: 2});
         cpu_access(addrs[k], 32'h1357_9BDF, (k == 0) ? 4'hF : 4'h0, o);
         e = sb.pop_front();
         exp_err_cnt++;
         tot_cnt++; if (o.rd !== e.rdata || o.lat !== e.lat)
            $display("FAIL unmapped_resp[%0d] got %h/%0d want %h/%0d", k, o.rd, o.lat, e.rdata, e.lat); else pass_cnt++;
         tot_cnt++; if (o.berr_rdy !== e.err || o.berr_tot !== 1)
            $display("FAIL unmapped_bus_error[%0d] got %b/%0d want 1/1", k, o.berr_rdy, o.berr_tot); else pass_cnt++;
         tot_cnt++; if (o.ram_seen || o.mmio_seen)
            $display("FAIL unmapped_no_slave[%0d] got %b%b want 00", k, o.ram_seen, o.mmio_seen); else pass_cnt++;
         tot_cnt++; if (err_addr !== addrs[k]) $display("FAIL unmapped_err_addr[%0d] got %h want %h", k, err_addr, addrs[k]); else pass_cnt++;
         tot_cnt++; if (err_count !== 8'(exp_err_cnt))
            $display("FAIL unmapped_err_count[%0d] got %0d want %0d", k, err_count, exp_err_cnt); else pass_cnt++;
         @(posedge clk);
      end
   endtask

   task automatic test_timeout();
      obs_t o;
      exp_t e;
      logic bad;
      mmio_delay = 0;
      sb.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b1, lat: 10});
      cpu_access(32'h1000_0010, 32'h0, 4'h0, o);
      e = sb.pop_front();
      exp_err_cnt++;
      tot_cnt++; if (o.rd !== e.rdata) $display("FAIL timeout_rdata got %h want %h", o.rd, e.rdata); else pass_cnt++;
      tot_cnt++; if (o.lat !== e.lat) $display("FAIL timeout_latency got %0d want %0d", o.lat, e.lat); else pass_cnt++;
      tot_cnt++; if (o.berr_rdy !== 1'b1 || o.slv_at_rdy !== 1'b0)
         $display("FAIL timeout_flags got err=%b valid=%b want err=1 valid=0", o.berr_rdy, o.slv_at_rdy); else pass_cnt++;
      tot_cnt++; if (err_addr !== 32'h1000_0010 || err_count !== 8'(exp_err_cnt))
         $display("FAIL timeout_err_log got %h/%0d want 10000010/%0d", err_addr, err_count, exp_err_cnt); else pass_cnt++;
      bad = 1'b0;
      @(negedge clk);
      @(negedge clk);
      mmio_force = 1'b1;
      @(negedge clk);
      mmio_force = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (mem_ready || bus_error || mmio_valid) bad = 1'b1;
      end
      tot_cnt++; if (bad !== 1'b0) $display("FAIL late_ready_ignored got activity=%b want 0", bad); else pass_cnt++;
      mmio_delay = 1;
      sb.push_back('{rdata: 32'h1234_5678, err: 1'b0, lat: 3});
      cpu_access(32'h0000_0010, 32'h0, 4'h0, o);
      e = sb.pop_front();
      tot_cnt++; if (o.rd !== e.rdata || o.lat !== e.lat)
         $display("FAIL after_timeout_ram got %h/%0d want %h/%0d", o.rd, o.lat, e.rdata, e.lat); else pass_cnt++;
      @(posedge clk);
   endtask

   task automatic test_back_to_back();
      obs_t o;
      exp_t e;
      sb.push_back('{rdata: 32'h1234_5678, err: 1'b0, lat: 3});
      sb.push_back('{rdata: 32'h05C3_053C, err: 1'b0, lat: 4});
      for (int k = 0; k < 2; k++) begin
         cpu_access((k == 0) ? 32'h10 : 32'h14, 32'h0, 4'h0, o);
         e = sb.pop_front();
         tot_cnt++; if (o.rd !== e.rdata || o.lat !== e.lat || o.berr_tot !== 0)
            $display("FAIL back_to_back[%0d] got %h/%0d/%0d want %h/%0d/0", k, o.rd, o.lat, o.berr_tot, e.rdata, e.lat); else pass_cnt++;
      end
      @(posedge clk);
   endtask

   task automatic test_err_saturate();
      obs_t o;
      for (int k = 0; k < 252; k++) begin
         cpu_access(32'h3000_0000, 32'h0, 4'h0, o);
         exp_err_cnt = (exp_err_cnt >= 255) ? 255 : exp_err_cnt + 1;
      end
      tot_cnt++; if (err_count !== 8'(exp_err_cnt))
         $display("FAIL err_count_saturate got %0d want %0d", err_count, exp_err_cnt); else pass_cnt++;
      cpu_access(32'h3000_0004, 32'h0, 4'h0, o);
      tot_cnt++; if (err_count !== 8'd255 || o.berr_rdy !== 1'b1 || err_addr !== 32'h3000_0004)
         $display("FAIL err_count_hold got %0d/%b/%h want 255/1/30000004", err_count, o.berr_rdy, err_addr); else pass_cnt++;
      @(posedge clk);
   endtask

   task automatic test_reset_midflight();
      obs_t o;
      exp_t e;
      mmio_delay = 0;
      @(negedge clk);
      mem_valid = 1'b1;
      mem_addr  = 32'h1000_0020;
      mem_wstrb = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      tot_cnt++; if (mmio_valid !== 1'b1) $display("FAIL midflight_valid got %b want 1", mmio_valid); else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
      mem_valid = 1'b0;
      @(posedge clk);
      #1;
      tot_cnt++; if ({mmio_valid, mem_ready, bus_error} !== 3'b000 || err_count !== 8'd0)
         $display("FAIL midflight_reset got v=%b r=%b e=%b cnt=%0d want 0/0/0/0", mmio_valid, mem_ready, bus_error, err_count); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      exp_err_cnt = 0;
      mmio_delay = 1;
      sb.push_back('{rdata: 32'h1234_5678, err: 1'b0, lat: 3});
      cpu_access(32'h0000_0010, 32'h0, 4'h0, o);
      e = sb.pop_front();
      tot_cnt++; if (o.rd !== e.rdata || o.lat !== e.lat || o.berr_tot !== 0)
         $display("FAIL after_reset_ram got %h/%0d/%0d want %h/%0d/0", o.rd, o.lat, o.berr_tot, e.rdata, e.lat); else pass_cnt++;
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout got no finish want finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      test_reset();
      test_ram_read();
      test_byte_write();
      test_mmio_read();
      test_unmapped();
      test_timeout();
      test_back_to_back();
      test_err_saturate();
      test_reset_midflight();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
